// File: rtl/cp0_unit.sv
// cp0_unit: system coprocessor beside the core. Holds Status, Cause, EPC,
// Count, Compare and PRId. It merges the external IRQ lines, the software
// interrupt bits and the Count/Compare timer into hw_interrupt/hw_cause.
module cp0_unit #(
  parameter logic [31:0] PRID      = 32'h0001_8000,
  parameter int unsigned COUNT_DIV = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  irq_i,
  input  logic        exception,
  input  logic [31:0] cause,
  input  logic [31:0] epc,
  input  logic        eret,
  input  logic [4:0]  cp0_addr_i,
  input  logic [31:0] cp0_data_i,
  input  logic        cp0_we_i,
  output logic [31:0] cp0_data_o,
  output logic        hw_interrupt,
  output logic [31:0] hw_cause,
  output logic [31:0] epc_o
);

  localparam logic [4:0] REG_COUNT   = 5'd9;
  localparam logic [4:0] REG_COMPARE = 5'd11;
  localparam logic [4:0] REG_STATUS  = 5'd12;
  localparam logic [4:0] REG_CAUSE   = 5'd13;
  localparam logic [4:0] REG_EPC     = 5'd14;
  localparam logic [4:0] REG_PRID    = 5'd15;

  localparam logic [7:0] PRESC_LAST = 8'(COUNT_DIV - 1);

  logic [7:0]  status_im;
  logic        status_exl;
  logic        status_ie;
  logic [1:0]  ip_sw;
  logic        ip_timer;
  logic [4:0]  irq_q;
  logic [4:0]  exc_code;
  logic [31:0] epc_q;
  logic [31:0] count_q;
  logic [31:0] compare_q;
  logic [7:0]  presc_q;

  logic        wr_count;
  logic        wr_compare;
  logic        wr_status;
  logic        wr_cause;
  logic        wr_epc;
  logic        presc_wrap;
  logic [7:0]  ip;
  logic [31:0] status_word;
  logic [31:0] cause_word;
  logic        unused_cause_bits;

  assign wr_count   = cp0_we_i && (cp0_addr_i == REG_COUNT);
  assign wr_compare = cp0_we_i && (cp0_addr_i == REG_COMPARE);
  assign wr_status  = cp0_we_i && (cp0_addr_i == REG_STATUS);
  assign wr_cause   = cp0_we_i && (cp0_addr_i == REG_CAUSE);
  assign wr_epc     = cp0_we_i && (cp0_addr_i == REG_EPC);
  assign presc_wrap = (presc_q == PRESC_LAST);

  assign ip          = {ip_timer, irq_q, ip_sw};
  assign status_word = {16'b0, status_im, 6'b0, status_exl, status_ie};
  assign cause_word  = {16'b0, ip, 1'b0, exc_code, 2'b0};

  assign unused_cause_bits = &{1'b0, cause[31:7], cause[1:0]};

  // Timer: free-running prescaler, Count with MTC0 override, sticky Compare match.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q   <= '0;
      count_q   <= '0;
      compare_q <= '1;
      ip_timer  <= 1'b0;
    end else begin
      presc_q <= presc_wrap ? '0 : presc_q + 8'd1;
      if (wr_count)
        count_q <= cp0_data_i;
      else if (presc_wrap)
        count_q <= count_q + 32'd1;
      if (wr_compare)
        compare_q <= cp0_data_i;
      if (wr_compare)
        ip_timer <= 1'b0;
      else if (count_q == compare_q)
        ip_timer <= 1'b1;
    end
  end

  // Status, Cause and EPC; an exception overrides MTC0 only on the fields it owns.
  always_ff @(posedge clk) begin
    if (rst) begin
      status_im  <= '0;
      status_ie  <= 1'b0;
      status_exl <= 1'b0;
      ip_sw      <= '0;
      irq_q      <= '0;
      exc_code   <= '0;
      epc_q      <= '0;
    end else begin
      irq_q <= irq_i;
      if (wr_status) begin
        status_im <= cp0_data_i[15:8];
        status_ie <= cp0_data_i[0];
      end
      // ERET also takes precedence over an MTC0 of EXL in the same cycle.
      if (exception)
        status_exl <= 1'b1;
      else if (eret)
        status_exl <= 1'b0;
      else if (wr_status)
        status_exl <= cp0_data_i[1];
      if (wr_cause)
        ip_sw <= cp0_data_i[9:8];
      if (exception) begin
        epc_q    <= epc;
        exc_code <= cause[6:2];
      end else if (wr_epc) begin
        epc_q <= cp0_data_i;
      end
    end
  end

  // MFC0 read mux, driven from pre-edge register state.
  always_comb begin
    cp0_data_o = '0;
    case (cp0_addr_i)
      REG_COUNT:   cp0_data_o = count_q;
      REG_COMPARE: cp0_data_o = compare_q;
      REG_STATUS:  cp0_data_o = status_word;
      REG_CAUSE:   cp0_data_o = cause_word;
      REG_EPC:     cp0_data_o = epc_q;
      REG_PRID:    cp0_data_o = PRID;
      default:     cp0_data_o = '0;
    endcase
  end

  assign hw_interrupt = status_ie & ~status_exl & (|(ip & status_im));
  assign hw_cause     = {16'b0, ip, 1'b0, 5'd0, 2'b0};
  assign epc_o        = epc_q;

endmodule

// File: tb/tb_cp0_unit.sv
// Self-checking bench for cp0_unit: two instances (COUNT_DIV 1 and 4) share
// one stimulus stream and are compared each cycle against a behavioural model.
module tb_cp0_unit;

  localparam logic [31:0] PRID = 32'h0001_8000;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  irq_i;
  logic        exception;
  logic [31:0] cause;
  logic [31:0] epc;
  logic        eret;
  logic [4:0]  cp0_addr_i;
  logic [31:0] cp0_data_i;
  logic        cp0_we_i;

  logic [31:0] u1_data, u4_data, u1_hwc, u4_hwc, u1_epc, u4_epc;
  logic        u1_hw, u4_hw;

  int unsigned total = 0;
  int unsigned bad   = 0;
  logic        chk_en = 1'b0;

  always #5 clk = ~clk;

  cp0_unit #(.PRID(PRID), .COUNT_DIV(1)) u1 (
    .clk(clk), .rst(rst), .irq_i(irq_i), .exception(exception), .cause(cause),
    .epc(epc), .eret(eret), .cp0_addr_i(cp0_addr_i), .cp0_data_i(cp0_data_i),
    .cp0_we_i(cp0_we_i), .cp0_data_o(u1_data), .hw_interrupt(u1_hw),
    .hw_cause(u1_hwc), .epc_o(u1_epc)
  );

  cp0_unit #(.PRID(PRID), .COUNT_DIV(4)) u4 (
    .clk(clk), .rst(rst), .irq_i(irq_i), .exception(exception), .cause(cause),
    .epc(epc), .eret(eret), .cp0_addr_i(cp0_addr_i), .cp0_data_i(cp0_data_i),
    .cp0_we_i(cp0_we_i), .cp0_data_o(u4_data), .hw_interrupt(u4_hw),
    .hw_cause(u4_hwc), .epc_o(u4_epc)
  );

  // Architectural view of CP0; n = clock edges since reset drives the timer.
  typedef struct packed {
    logic [7:0]  im;
    logic        exl;
    logic        ie;
    logic [1:0]  sw;
    logic        ip7;
    logic [4:0]  irqq;
    logic [4:0]  exc;
    logic [31:0] epc;
    logic [31:0] count;
    logic [31:0] cmp;
    logic [31:0] n;
  } mst_t;

  mst_t m1, m4;

  function automatic mst_t reset_state();
    mst_t t;
    t = '0;
    t.cmp = 32'hFFFF_FFFF;
    return t;
  endfunction

  function automatic mst_t step(mst_t s, int unsigned div);
    mst_t t;
    if (rst) return reset_state();
    t = s;
    t.n = s.n + 32'd1;
    t.irqq = irq_i;
    if (cp0_we_i && cp0_addr_i == 5'd11) begin
      t.cmp = cp0_data_i;
      t.ip7 = 1'b0;
    end else if (s.count == s.cmp) begin
      t.ip7 = 1'b1;
    end
    if (cp0_we_i && cp0_addr_i == 5'd9) t.count = cp0_data_i;
    else if ((s.n % div) == div - 1) t.count = s.count + 32'd1;
    if (cp0_we_i && cp0_addr_i == 5'd12) begin
      t.im = cp0_data_i[15:8];
      t.ie = cp0_data_i[0];
    end
    if (exception) t.exl = 1'b1;
    else if (eret) t.exl = 1'b0;
    else if (cp0_we_i && cp0_addr_i == 5'd12) t.exl = cp0_data_i[1];
    if (cp0_we_i && cp0_addr_i == 5'd13) t.sw = cp0_data_i[9:8];
    if (exception) begin
      t.epc = epc;
      t.exc = cause[6:2];
    end else if (cp0_we_i && cp0_addr_i == 5'd14) begin
      t.epc = cp0_data_i;
    end
    return t;
  endfunction

  function automatic logic [7:0] ip_of(mst_t s);
    return {s.ip7, s.irqq, s.sw};
  endfunction

  function automatic logic [31:0] rd(mst_t s, logic [4:0] a);
    case (a)
      5'd9:    return s.count;
      5'd11:   return s.cmp;
      5'd12:   return {16'b0, s.im, 6'b0, s.exl, s.ie};
      5'd13:   return {16'b0, ip_of(s), 1'b0, s.exc, 2'b0};
      5'd14:   return s.epc;
      5'd15:   return PRID;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic hw_of(mst_t s);
    return s.ie && !s.exl && ((ip_of(s) & s.im) != 8'd0);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  // Model advances on the same edge as the DUTs.
  always @(posedge clk) begin
    m1 = step(m1, 1);
    m4 = step(m4, 4);
  end

  // Compare every output of both instances mid-cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("u1.data", u1_data, rd(m1, cp0_addr_i));
      chk("u1.hw_interrupt", {31'd0, u1_hw}, {31'd0, hw_of(m1)});
      chk("u1.hw_cause", u1_hwc, {16'b0, ip_of(m1), 8'b0});
      chk("u1.epc_o", u1_epc, m1.epc);
      chk("u4.data", u4_data, rd(m4, cp0_addr_i));
      chk("u4.hw_interrupt", {31'd0, u4_hw}, {31'd0, hw_of(m4)});
      chk("u4.hw_cause", u4_hwc, {16'b0, ip_of(m4), 8'b0});
      chk("u4.epc_o", u4_epc, m4.epc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    cp0_we_i   = 1'b1;
    cp0_addr_i = a;
    cp0_data_i = d;
    tick();
    cp0_we_i = 1'b0;
  endtask

  task automatic peek(input logic [4:0] a);
    cp0_addr_i = a;
    #1;
  endtask

  initial begin
    rst = 1'b1; irq_i = 5'h1F; exception = 1'b0; cause = '0; epc = '0;
    eret = 1'b0; cp0_addr_i = '0; cp0_data_i = '0; cp0_we_i = 1'b0;
    m1 = reset_state();
    m4 = reset_state();

    // Reset held two cycles with all IRQ lines high
    tick(); tick();
    chk("rst_hw", {31'd0, u1_hw}, 32'd0);
    chk("rst_hwc", u1_hwc, 32'd0);
    chk("rst_epc_o", u4_epc, 32'd0);
    peek(5'd12); chk("rst_status", u1_data, 32'd0);
    peek(5'd13); chk("rst_cause", u4_data, 32'd0);
    peek(5'd14); chk("rst_epc", u1_data, 32'd0);
    peek(5'd11); chk("rst_compare", u1_data, 32'hFFFF_FFFF);
    peek(5'd15); chk("rst_prid", u4_data, PRID);
    rst = 1'b0; irq_i = '0;
    chk_en = 1'b1;

    // External IRQ through IM2
    mtc0(5'd12, 32'h0000_0401);
    irq_i = 5'h01;
    #1 chk("irq_before", {31'd0, u1_hw}, 32'd0);
    tick();
    chk("irq_rise", {31'd0, u1_hw}, 32'd1);
    chk("irq_cause", u1_hwc, 32'h0000_0400);
    irq_i = '0;
    tick();
    chk("irq_fall", {31'd0, u1_hw}, 32'd0);

    // Count/Compare timer on the divide-by-4 instance
    mtc0(5'd11, 32'd3);
    mtc0(5'd9, 32'd0);
    mtc0(5'd11, 32'd3);
    mtc0(5'd12, 32'h0000_8001);
    chk("timer_idle", {31'd0, u4_hw}, 32'd0);
    for (int i = 0; i < 20; i++) begin
      if (u4_hw) break;
      tick();
    end
    chk("timer_rise", {31'd0, u4_hw}, 32'd1);
    tick(); tick(); tick();
    peek(5'd13); chk("timer_sticky", {31'd0, u4_data[15]}, 32'd1);
    mtc0(5'd11, 32'h0000_1000);
    chk("timer_clear", {31'd0, u4_hw}, 32'd0);

    // Exception masks a pending interrupt, ERET re-enables it
    irq_i = 5'h01;
    mtc0(5'd12, 32'h0000_0401);
    chk("exc_pre_hw", {31'd0, u1_hw}, 32'd1);
    exception = 1'b1; cause = 32'h0000_0030; epc = 32'h0000_0100;
    tick();
    exception = 1'b0;
    chk("exc_epc", u1_epc, 32'h0000_0100);
    chk("exc_hw", {31'd0, u1_hw}, 32'd0);
    peek(5'd13); chk("exc_code", {27'd0, u1_data[6:2]}, 32'd12);
    peek(5'd12); chk("exc_exl", {31'd0, u1_data[1]}, 32'd1);
    eret = 1'b1;
    tick();
    eret = 1'b0;
    chk("eret_exl", {31'd0, u1_data[1]}, 32'd0);
    chk("eret_hw", {31'd0, u1_hw}, 32'd1);
    irq_i = '0;

    // Exception + ERET + MTC0 Status=0 in one cycle
    exception = 1'b1; eret = 1'b1;
    mtc0(5'd12, 32'd0);
    exception = 1'b0; eret = 1'b0;
    peek(5'd12); chk("coll_status", u1_data, 32'h0000_0002);

    // Compare write wins over a same-cycle match
    mtc0(5'd11, 32'd50);
    mtc0(5'd9, 32'd50);
    mtc0(5'd11, 32'd50);
    peek(5'd13); chk("coll_ip7", {31'd0, u1_data[15]}, 32'd0);

    // Count wrap, then match on the following edge
    mtc0(5'd11, 32'd0);
    mtc0(5'd9, 32'hFFFF_FFFF);
    peek(5'd9); chk("wrap_pre", u1_data, 32'hFFFF_FFFF);
    tick();
    chk("wrap_zero", u1_data, 32'd0);
    peek(5'd13); chk("wrap_no_ip7", {31'd0, u1_data[15]}, 32'd0);
    tick();
    chk("wrap_ip7", {31'd0, u1_data[15]}, 32'd1);

    // Randomised traffic, including mid-run resets
    for (int i = 0; i < 4000; i++) begin
      int unsigned sel;
      rst       = ($urandom_range(0, 255) == 0);
      irq_i     = 5'($urandom);
      exception = ($urandom_range(0, 15) == 0);
      eret      = ($urandom_range(0, 15) == 0);
      cause     = $urandom;
      epc       = $urandom;
      cp0_we_i  = ($urandom_range(0, 3) == 0);
      sel = $urandom_range(0, 7);
      case (sel)
        0: cp0_addr_i = 5'd9;
        1: cp0_addr_i = 5'd11;
        2: cp0_addr_i = 5'd12;
        3: cp0_addr_i = 5'd13;
        4: cp0_addr_i = 5'd14;
        5: cp0_addr_i = 5'd15;
        default: cp0_addr_i = 5'($urandom);
      endcase
      if (sel <= 1)
        cp0_data_i = (($urandom_range(0, 1) == 0) ? m1.count : m4.count) + $urandom_range(0, 3);
      else
        cp0_data_i = $urandom;
      tick();
    end
    rst = 1'b0; cp0_we_i = 1'b0; exception = 1'b0; eret = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
